// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned ZERO_REG           = 0;
  localparam logic [7:0]  ZERO_DROP_MAX      = 8'hFF;

  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } wr_req_t;

  // Saturating increment for the dropped-write counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == ZERO_DROP_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr (mod NUM_REQ) wins.
module rr_arbiter
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
)
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        idx = IDX_W'((32'(ptr) + 32'(k)) % NUM_REQ);
        if (!grant_any && valid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          grant_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the single regfile write port with a one-cycle stage.
// Optional read forwarding of the staged write: REGFILE_WRITE_BYPASS_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
)
(
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          hold,
  output logic                          RegWrite,
  output logic [ADDR_WIDTH-1:0]         WriteRegister,
  output logic [DATA_WIDTH-1:0]         WriteData,
  output logic [7:0]                    zero_drops
`ifdef REGFILE_WRITE_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0]         ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]         ReadRegister2,
  input  logic [DATA_WIDTH-1:0]         rf_ReadData1,
  input  logic [DATA_WIDTH-1:0]         rf_ReadData2,
  output logic [DATA_WIDTH-1:0]         ReadData1,
  output logic [DATA_WIDTH-1:0]         ReadData2
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_is_zero;
  logic [IDX_W-1:0]      next_ptr;

  // Grants are suppressed during reset and while hold is asserted.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .enable    (!hold && !Reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready   = grant;
  assign sel_addr    = req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data    = req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_is_zero = (sel_addr == ADDR_WIDTH'(ZERO_REG));
  assign next_ptr    = IDX_W'((32'(grant_idx) + 32'd1) % NUM_REQ);

  // Stage register: address/data persist across idle cycles, enable is one-shot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr        <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      zero_drops    <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (grant_any) begin
        rr_ptr <= next_ptr;
        if (sel_is_zero) begin
          zero_drops <= sat_inc8(zero_drops);
        end else begin
          RegWrite      <= 1'b1;
          WriteRegister <= sel_addr;
          WriteData     <= sel_data;
        end
      end
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // Forward the staged write to readers before it lands in the regfile.
  always_comb begin
    ReadData1 = rf_ReadData1;
    ReadData2 = rf_ReadData2;
    if (RegWrite && (WriteRegister == ReadRegister1) &&
        (ReadRegister1 != ADDR_WIDTH'(ZERO_REG)))
      ReadData1 = WriteData;
    if (RegWrite && (WriteRegister == ReadRegister2) &&
        (ReadRegister2 != ADDR_WIDTH'(ZERO_REG)))
      ReadData2 = WriteData;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a queue-based requester model.
// Build with REGFILE_WRITE_BYPASS_EN defined to also check read forwarding.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             hold = 1'b0;
  logic             RegWrite;
  logic [AW-1:0]    WriteRegister;
  logic [DW-1:0]    WriteData;
  logic [7:0]       zero_drops;
`ifdef REGFILE_WRITE_BYPASS_EN
  logic [AW-1:0]    ReadRegister1 = '0, ReadRegister2 = '0;
  logic [DW-1:0]    rf_ReadData1 = '0, rf_ReadData2 = '0;
  logic [DW-1:0]    ReadData1, ReadData2;
`endif

  regfile_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .hold          (hold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .zero_drops    (zero_drops)
`ifdef REGFILE_WRITE_BYPASS_EN
    ,
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .rf_ReadData1  (rf_ReadData1),
    .rf_ReadData2  (rf_ReadData2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int      cyc;
    wr_req_t w;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            mv[NR];
  logic [AW-1:0] ma[NR];
  logic [DW-1:0] md[NR];
  int            m_ptr = 0;
  int            m_drops = 0;
  int            gcount[NR];

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = mv[i];
      req_addr[i*AW +: AW]  = ma[i];
      req_data[i*DW +: DW]  = md[i];
    end
  endtask

  // One cycle: refresh requesters, predict the grant, then advance to the next edge.
  // mode 0 random, 1 saturated nonzero, 2 r0 flood on requester 0, 3 no new requests.
  task automatic step(input int mode, input bit hold_in, output int g);
    int best;
    int d;
    logic [NR-1:0] exp_ready;
    for (int i = 0; i < NR; i++) begin
      if (!mv[i]) begin
        case (mode)
          0: if ($urandom_range(0, 2) != 0) begin
               mv[i] = 1'b1; ma[i] = AW'($urandom_range(0, 7)); md[i] = $urandom;
             end
          1: begin mv[i] = 1'b1; ma[i] = AW'($urandom_range(1, 31)); md[i] = $urandom; end
          2: if (i == 0) begin mv[i] = 1'b1; ma[i] = '0; md[i] = $urandom; end
          default: ;
        endcase
      end
    end
    drive();
    hold = hold_in;
`ifdef REGFILE_WRITE_BYPASS_EN
    ReadRegister1 = AW'($urandom_range(0, 7));
    ReadRegister2 = AW'($urandom_range(0, 7));
    rf_ReadData1  = $urandom;
    rf_ReadData2  = $urandom;
`endif
    #2;
    g = -1;
    best = NR;
    if (!hold_in) begin
      for (int i = 0; i < NR; i++) begin
        d = (i - m_ptr + NR) % NR;
        if (mv[i] && d < best) begin best = d; g = i; end
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      if (ma[g] == '0) m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
      else sb.push_back('{cyc: cyc, w: '{addr: ma[g], data: md[g]}});
      m_ptr = (g + 1) % NR;
      mv[g] = 1'b0;
    end
    @(posedge Clk);
    #1;
    check("zero_drops", 64'(zero_drops), 64'(m_drops));
  endtask

  // Monitor: every staged write must match the oldest expected entry, one cycle later.
  exp_t e;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (RegWrite) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_write: got addr %0h data %0h want no write", WriteRegister, WriteData);
        end else begin
          e = sb.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.cyc + 1));
          check("write_addr", 64'(WriteRegister), 64'(e.w.addr));
          check("write_data", 64'(WriteData), 64'(e.w.data));
`ifdef REGFILE_WRITE_BYPASS_EN
          check("bypass1", 64'(ReadData1),
                64'((ReadRegister1 == e.w.addr && ReadRegister1 != '0) ? e.w.data : rf_ReadData1));
          check("bypass2", 64'(ReadData2),
                64'((ReadRegister2 == e.w.addr && ReadRegister2 != '0) ? e.w.data : rf_ReadData2));
`endif
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
          e = sb.pop_front();
          total++; bad++;
          $display("FAIL missing_write: got RegWrite 0 want write r%0d=%0h", e.w.addr, e.w.data);
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        check("bypass1_idle", 64'(ReadData1), 64'(rf_ReadData1));
        check("bypass2_idle", 64'(ReadData2), 64'(rf_ReadData2));
`endif
      end
    end
  end

  initial begin
    int g;
    for (int i = 0; i < NR; i++) begin mv[i] = 1'b0; ma[i] = '0; md[i] = '0; end

    // Reset with requests pending: no grants, cleared outputs.
    req_valid = '1;
    #3;
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_regwrite", 64'(RegWrite), 64'(0));
    check("reset_wreg", 64'(WriteRegister), 64'(0));
    check("reset_wdata", 64'(WriteData), 64'(0));
    check("reset_drops", 64'(zero_drops), 64'(0));
    req_valid = '0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Single request, then two-way contention.
    mv[0] = 1'b1; ma[0] = 5'd2; md[0] = 32'd42;
    step(3, 1'b0, g);
    mv[0] = 1'b1; ma[0] = 5'd3; md[0] = 32'd15;
    mv[1] = 1'b1; ma[1] = 5'd4; md[1] = 32'd7;
    step(3, 1'b0, g);
    step(3, 1'b0, g);
    step(3, 1'b0, g);

    // Fairness under saturation.
    for (int i = 0; i < NR; i++) gcount[i] = 0;
    for (int n = 0; n < 8; n++) begin
      step(1, 1'b0, g);
      if (g >= 0) gcount[g]++;
    end
    check("fair_req0", 64'(gcount[0]), 64'(4));
    check("fair_req1", 64'(gcount[1]), 64'(4));

    // Random traffic with occasional hold.
    for (int n = 0; n < 300; n++) step(0, $urandom_range(0, 6) == 0, g);

    // Drain, then flood r0 writes to reach saturation.
    for (int n = 0; n < 4; n++) step(3, 1'b0, g);
    for (int n = 0; n < 260; n++) step(2, 1'b0, g);
    check("drops_saturated", 64'(zero_drops), 64'(255));
    for (int n = 0; n < 3; n++) step(3, 1'b0, g);

    // Hold blocks a pending request; release grants it.
    mv[1] = 1'b1; ma[1] = 5'd9; md[1] = 32'h1234;
    for (int n = 0; n < 3; n++) step(3, 1'b1, g);
    step(3, 1'b0, g);
    check("stage_loaded", 64'(RegWrite), 64'(1));

    // Reset pulse while the stage is loaded.
    mv[0] = 1'b1; ma[0] = 5'd3; md[0] = 32'h55;
    drive();
    Reset = 1'b1;
    #1;
    check("rst_pulse_regwrite", 64'(RegWrite), 64'(0));
    check("rst_pulse_ready", 64'(req_ready), 64'(0));
    check("rst_pulse_drops", 64'(zero_drops), 64'(0));
    Reset = 1'b0;
    sb.delete();
    m_ptr = 0;
    m_drops = 0;

    for (int n = 0; n < 40; n++) step(0, 1'b0, g);
    for (int n = 0; n < 4; n++) step(3, 1'b0, g);
    @(negedge Clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
